ie_mem_loader: RTL and testbench
================================

IE_MEM_LOADER -- requirements
Module: ie_mem_loader

Interface
REQ-001 Parameters (name, default, meaning), SHALL be:
- ADDR_W, 16, memory address width.
- DATA_W, 8, memory data width.
- DEPTH, 64, max entries per listing.
- NUM_LST, 4, number of listings.
- VERIFY, 1, read-back compare enabled (0 = write only).
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- tbl_we, in, 1, table entry write strobe.
- tbl_sel, in, clog2(NUM_LST), listing select for table/length write.
- tbl_idx, in, clog2(DEPTH), entry index.
- tbl_addr, in, ADDR_W, entry target address.
- tbl_data, in, DATA_W, entry byte.
- len_we, in, 1, listing length write strobe.
- len_val, in, clog2(DEPTH)+1, listing length.
- start, in, 1, begin loading listing start_sel.
- start_sel, in, clog2(NUM_LST), listing to load.
- mem_req, out, 1, memory request.
- mem_we, out, 1, 1 = write, 0 = read.
- mem_addr, out, ADDR_W, request address.
- mem_wdata, out, DATA_W, write data.
- mem_rdata, in, DATA_W, read data, valid in the mem_ack cycle.
- mem_ack, in, 1, request accepted/completed.
- busy, out, 1, load in progress.
- done, out, 1, one-cycle completion pulse.
- cpu_hold, out, 1, CPU stall.
- err, out, 1, sticky mismatch flag.
- err_cnt, out, 8, saturating mismatch count.
- err_addr, out, ADDR_W, address of first mismatch.

Function
REQ-003 States SHALL be IDLE, WR, RD, CMP, FIN.
REQ-004 In IDLE, start SHALL latch start_sel and clear the entry index, err, err_cnt and err_addr.
- Length 0: IDLE->FIN with no memory access.
- Otherwise: IDLE->WR, with mem_req high on the next cycle.
REQ-005 In WR:
- mem_req=1, mem_we=1; mem_addr/mem_wdata = current entry, held stable until mem_ack.
- On mem_ack: go to RD if VERIFY=1; otherwise advance the index, or go to FIN after the last entry.
REQ-006 In RD, mem_req=1 and mem_we=0 with the same address; on mem_ack, mem_rdata SHALL be registered and the state SHALL go to CMP.
REQ-007 CMP SHALL last one cycle with mem_req=0.
- On mismatch: err=1, err_cnt++ saturating at 255; err_addr loaded only if err_cnt was 0.
- Then advance to the next entry (WR) or to FIN.
REQ-008 mem_req SHALL deassert in the cycle after mem_ack; a back-to-back request SHALL start no earlier than that.
REQ-009 FIN SHALL last one cycle with done=1, then go to IDLE; err, err_cnt and err_addr SHALL hold until the next accepted start.
REQ-010 busy SHALL be 1 in WR, RD, CMP and FIN, and 0 in IDLE.
REQ-011 cpu_hold SHALL be 1 from reset until the first done, and 1 whenever busy.
REQ-012 start while busy SHALL be ignored.
REQ-013 tbl_we and len_we while busy SHALL be ignored.
REQ-014 tbl_we and len_we in the same cycle as an accepted start SHALL be ignored.
REQ-015 len_val > DEPTH SHALL be stored as DEPTH.
REQ-016 Table and length writes SHALL take effect at the next clk edge; the table SHALL be readable by the loader in the cycle after the write.
REQ-017 Throughput:
- VERIFY=0, zero-wait ack: 2 cycles per entry.
- VERIFY=1, zero-wait ack: 5 cycles per entry.
- Total load latency (start to done) = entries*per-entry + 2.

Reset
REQ-018 rst_n low SHALL asynchronously force:
- State IDLE, all lengths 0, cpu_hold=1.
- mem_req, mem_we, busy, done, err = 0.
- err_cnt = 0, err_addr = 0, mem_addr = 0, mem_wdata = 0.
REQ-019 Table entry contents SHALL NOT be reset; a listing with length 0 SHALL never be read.
REQ-020 Reset during any state SHALL abort the load immediately with no further memory access; a pending mem_ack after reset SHALL be ignored.

Verification
REQ-021 Listing 0 = {0x0100:A0, 0x0101:00, 0x0102:84}, len 3, VERIFY=1, ideal memory -> three write/read pairs in order; done at cycle 17 after start; err=0; cpu_hold falls after done.
REQ-022 Same listing, memory corrupts reads at 0x0101 to 0xFF -> err=1, err_cnt=1, err_addr=0x0101, all three entries still written.
REQ-023 mem_ack delayed 3 cycles per request -> mem_addr/mem_wdata stable throughout the wait; still exactly 6 requests.
REQ-024 len_val=0 then start -> done one cycle later with mem_req never asserted; len_val=200 -> 64 entries loaded.
REQ-025 start and tbl_we asserted while busy -> no effect on the sequence or the table; a second start after done reloads listing 1 and clears the error fields.
REQ-026 rst_n low mid-RD -> mem_req low without a clock edge; after release, state IDLE, lengths 0, cpu_hold=1.

Source files
------------

// File: rtl/ie_mem_loader.sv
// Loads byte listings from an internal table into memory.
// Can read each byte back and compare it, logging mismatches.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   tbl_we/sel/idx    table entry write (tbl_addr, tbl_data)
//   len_we, len_val   listing length write (for listing tbl_sel)
//   start, start_sel  begin loading a listing
//   mem_*             memory request/ack port
//   busy, done        load in progress / completion pulse
//   cpu_hold          CPU stall
//   err, err_cnt      sticky mismatch flag, saturating count
//   err_addr          address of the first mismatch
module ie_mem_loader #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 64,
  parameter int NUM_LST = 4,
  parameter int VERIFY  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tbl_we,
  input  logic [$clog2(NUM_LST)-1:0] tbl_sel,
  input  logic [$clog2(DEPTH)-1:0]   tbl_idx,
  input  logic [ADDR_W-1:0]          tbl_addr,
  input  logic [DATA_W-1:0]          tbl_data,
  input  logic                       len_we,
  input  logic [$clog2(DEPTH):0]     len_val,
  input  logic                       start,
  input  logic [$clog2(NUM_LST)-1:0] start_sel,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_ack,
  output logic                       busy,
  output logic                       done,
  output logic                       cpu_hold,
  output logic                       err,
  output logic [7:0]                 err_cnt,
  output logic [ADDR_W-1:0]          err_addr
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;
  localparam int SW = $clog2(NUM_LST);

  typedef enum logic [2:0] {
    IDLE, WR, RD, CMP, FIN
  } state_t;

  state_t state, state_n;
  logic   req_ph, req_ph_n;

  logic [ADDR_W-1:0] t_addr [NUM_LST][DEPTH];
  logic [DATA_W-1:0] t_data [NUM_LST][DEPTH];
  logic [LW-1:0]     lens   [NUM_LST];

  logic [SW-1:0]     sel;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] rdata_q;
  logic              hold_q;

  logic start_acc;
  logic wr_ok;
  logic last;
  logic adv;
  logic cap;
  logic cmp_en;

  assign start_acc = start && (state == IDLE);
  assign wr_ok     = !busy && !start_acc;
  assign last      = ({1'b0, idx} + LW'(1)) == lens[sel];

  assign busy     = (state != IDLE);
  assign done     = (state == FIN);
  assign mem_we   = (state == WR);
  assign cpu_hold = hold_q || busy;
  // Each access spends one set-up cycle with the request low,
  // so the request always drops in the cycle after an ack.
  assign mem_req  = ((state == WR) || (state == RD)) && req_ph;

  // Entry storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (tbl_we && wr_ok) begin
      t_addr[tbl_sel][tbl_idx] <= tbl_addr;
      t_data[tbl_sel][tbl_idx] <= tbl_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LST; i++)
        lens[i] <= '0;
    end else if (len_we && wr_ok) begin
      if (len_val > LW'(DEPTH))
        lens[tbl_sel] <= LW'(DEPTH);
      else
        lens[tbl_sel] <= len_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      req_ph <= 1'b0;
    end else begin
      state  <= state_n;
      req_ph <= req_ph_n;
    end
  end

  always_comb begin
    state_n  = state;
    req_ph_n = req_ph;
    adv      = 1'b0;
    cap      = 1'b0;
    cmp_en   = 1'b0;
    unique case (state)
      IDLE: begin
        req_ph_n = 1'b0;
        if (start) begin
          if (lens[start_sel] == '0)
            state_n = FIN;
          else
            state_n = WR;
        end
      end
      WR: begin
        if (!req_ph) begin
          req_ph_n = 1'b1;
        end else if (mem_ack) begin
          req_ph_n = 1'b0;
          if (VERIFY != 0) begin
            state_n = RD;
          end else begin
            adv     = !last;
            state_n = last ? FIN : WR;
          end
        end
      end
      RD: begin
        if (!req_ph) begin
          req_ph_n = 1'b1;
        end else if (mem_ack) begin
          req_ph_n = 1'b0;
          cap      = 1'b1;
          state_n  = CMP;
        end
      end
      CMP: begin
        cmp_en  = 1'b1;
        adv     = !last;
        state_n = last ? FIN : WR;
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n  = IDLE;
        req_ph_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= '0;
      idx       <= '0;
      rdata_q   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
      err_cnt   <= '0;
      err_addr  <= '0;
      hold_q    <= 1'b1;
    end else begin
      if (start_acc) begin
        sel      <= start_sel;
        idx      <= '0;
        err      <= 1'b0;
        err_cnt  <= '0;
        err_addr <= '0;
      end
      // Latch the entry in the set-up cycle; it then stays
      // put for the write, the read-back and the compare.
      if ((state == WR) && !req_ph) begin
        mem_addr  <= t_addr[sel][idx];
        mem_wdata <= t_data[sel][idx];
      end
      if (cap)
        rdata_q <= mem_rdata;
      if (cmp_en && (rdata_q != mem_wdata)) begin
        err <= 1'b1;
        if (err_cnt != 8'hFF)
          err_cnt <= err_cnt + 8'd1;
        if (err_cnt == 8'h00)
          err_addr <= mem_addr;
      end
      if (adv)
        idx <= idx + IW'(1);
      if (state == FIN)
        hold_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ie_mem_loader.sv
// Self-checking bench for ie_mem_loader.
// Vector table of loads plus hand-written corner sequences.
module tb_ie_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tbl_we = 1'b0;
  logic [1:0]  tbl_sel = '0;
  logic [5:0]  tbl_idx = '0;
  logic [15:0] tbl_addr = '0;
  logic [7:0]  tbl_data = '0;
  logic        len_we = 1'b0;
  logic [6:0]  len_val = '0;
  logic        start = 1'b0;
  logic [1:0]  start_sel = '0;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        cpu_hold;
  logic        err;
  logic [7:0]  err_cnt;
  logic [15:0] err_addr;

  ie_mem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tbl_we    (tbl_we),
    .tbl_sel   (tbl_sel),
    .tbl_idx   (tbl_idx),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .len_we    (len_we),
    .len_val   (len_val),
    .start     (start),
    .start_sel (start_sel),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done),
    .cpu_hold  (cpu_hold),
    .err       (err),
    .err_cnt   (err_cnt),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  // Memory model: ack after ack_dly waiting cycles, optional
  // read corruption at 0x0101.
  logic [7:0]  mem [0:65535];
  int          ack_dly = 0;
  bit          cor = 1'b0;
  int          wcnt = 0;
  int          reqs = 0;
  int          unstable = 0;
  bit          pend = 1'b0;
  logic [15:0] paddr;
  logic [7:0]  pdata;
  logic        pwe;

  assign mem_ack   = mem_req && (wcnt == ack_dly);
  assign mem_rdata = (cor && mem_addr == 16'h0101) ?
                     8'hFF : mem[mem_addr];

  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      reqs = reqs + 1;
      if (mem_we)
        mem[mem_addr] <= mem_wdata;
    end
    if (pend && mem_req &&
        (mem_addr != paddr || mem_wdata != pdata || mem_we != pwe))
      unstable = unstable + 1;
    pend  <= mem_req && !mem_ack;
    paddr <= mem_addr;
    pdata <= mem_wdata;
    pwe   <= mem_we;
    wcnt  <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  // Bench-side model of the loader's table.
  logic [15:0] m_addr [4][64];
  logic [7:0]  m_data [4][64];
  int          m_len  [4];

  task automatic put_entry(input int s, input int i,
                           input int a, input int d);
    @(negedge clk);
    tbl_we   = 1'b1;
    tbl_sel  = 2'(s);
    tbl_idx  = 6'(i);
    tbl_addr = 16'(a);
    tbl_data = 8'(d);
    m_addr[s][i] = 16'(a);
    m_data[s][i] = 8'(d);
    @(posedge clk);
    #1 tbl_we = 1'b0;
  endtask

  task automatic put_len(input int s, input int l);
    @(negedge clk);
    len_we  = 1'b1;
    tbl_sel = 2'(s);
    len_val = 7'(l);
    m_len[s] = (l > 64) ? 64 : l;
    @(posedge clk);
    #1 len_we = 1'b0;
  endtask

  typedef struct {
    int sel;
    int dly;
    bit cor;
    int lat;
    int reqs;
    int err;
    int ecnt;
    int eaddr;
  } vec_t;

  // inj: 0 none, 1 start/table/length writes while busy,
  //      2 table/length write in the start cycle.
  task automatic run_vec(input vec_t v, input int inj);
    int n;
    int bad;
    int r0;
    int u0;
    cor     = v.cor;
    ack_dly = v.dly;
    r0 = reqs;
    u0 = unstable;
    @(negedge clk);
    start     = 1'b1;
    start_sel = 2'(v.sel);
    if (inj == 2) begin
      tbl_we   = 1'b1;
      tbl_sel  = 2'(v.sel);
      tbl_idx  = 6'd0;
      tbl_addr = 16'h0200;
      tbl_data = 8'h99;
      len_we   = 1'b1;
      len_val  = 7'd1;
    end
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    tbl_we = 1'b0;
    len_we = 1'b0;
    n = 1;
    while (!done && n < 2000) begin
      if (inj == 1 && n == 3) begin
        start     = 1'b1;
        start_sel = 2'd1;
        tbl_we    = 1'b1;
        tbl_sel   = 2'd0;
        tbl_idx   = 6'd2;
        tbl_addr  = 16'h0102;
        tbl_data  = 8'h55;
        len_we    = 1'b1;
        len_val   = 7'd1;
      end
      if (inj == 1 && n == 4) begin
        start  = 1'b0;
        tbl_we = 1'b0;
        len_we = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start  = 1'b0;
    tbl_we = 1'b0;
    len_we = 1'b0;
    chk("latency", n + 1, v.lat);
    chk("req_count", reqs - r0, v.reqs);
    chk("err", int'(err), v.err);
    chk("err_cnt", int'(err_cnt), v.ecnt);
    chk("err_addr", int'(err_addr), v.eaddr);
    chk("addr_stable", unstable - u0, 0);
    @(negedge clk);
    chk("hold_after", int'({busy, cpu_hold, done}), 0);
    bad = 0;
    for (int i = 0; i < m_len[v.sel]; i++)
      if (mem[m_addr[v.sel][i]] !== m_data[v.sel][i])
        bad++;
    chk("mem_content", bad, 0);
    cor = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    int n;
    vecs[0] = '{0, 0, 1'b0, 17,   6, 0, 0, 0};
    vecs[1] = '{0, 0, 1'b1, 17,   6, 1, 1, 16'h0101};
    vecs[2] = '{0, 3, 1'b0, 35,   6, 0, 0, 0};
    vecs[3] = '{3, 0, 1'b0, 2,    0, 0, 0, 0};
    vecs[4] = '{2, 0, 1'b0, 322, 128, 0, 0, 0};

    #12;
    @(negedge clk);
    chk("rst_hold", int'(cpu_hold), 1);
    chk("rst_busy", int'({busy, done, mem_req, mem_we}), 0);
    chk("rst_err", int'({err, err_cnt}), 0);
    chk("rst_err_addr", int'(err_addr), 0);
    chk("rst_mem_bus", int'({mem_addr, mem_wdata}), 0);
    rst_n = 1'b1;

    put_entry(0, 0, 16'h0100, 8'hA0);
    put_entry(0, 1, 16'h0101, 8'h00);
    put_entry(0, 2, 16'h0102, 8'h84);
    put_len(0, 3);
    put_entry(1, 0, 16'h0200, 8'h11);
    put_entry(1, 1, 16'h0201, 8'h22);
    put_len(1, 2);
    for (int i = 0; i < 64; i++)
      put_entry(2, i, 16'h2000 + i, (i * 7 + 3) & 8'hFF);
    put_len(2, 200);
    put_len(3, 0);

    @(negedge clk);
    chk("hold_before_done", int'(cpu_hold), 1);

    for (int k = 0; k < 5; k++)
      run_vec(vecs[k], 0);

    // Writes and a start while busy, ending with an error.
    run_vec(vecs[1], 1);
    // Next start reloads listing 1 and clears the error.
    run_vec('{1, 0, 1'b0, 12, 4, 0, 0, 0}, 0);
    // Table/length write alongside the start is dropped.
    run_vec('{1, 0, 1'b0, 12, 4, 0, 0, 0}, 2);

    // Reset while a read is waiting on its ack.
    ack_dly = 3;
    @(negedge clk);
    start     = 1'b1;
    start_sel = 2'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(mem_req && !mem_we) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_rd", int'(mem_req && !mem_we), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_req", int'(mem_req), 0);
    chk("rst_async_busy", int'(busy), 0);
    chk("rst_async_hold", int'(cpu_hold), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_hold", int'(cpu_hold), 1);
    chk("post_rst_state", int'({busy, done, err}), 0);
    for (int s = 0; s < 4; s++)
      m_len[s] = 0;
    // Lengths were cleared: an immediate done, no access.
    run_vec('{0, 0, 1'b0, 2, 0, 0, 0, 0}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
